axi_write_seq: RTL and testbench

- Sequencer in front of the fixed-burst AXI write engine (`axi_write_burst_fixed`).
- Accepts one write job: start address plus byte length up to 64 KiB − 8.
- Splits the job into chunks of at most 256 bytes that never cross a 4 KiB boundary.
- For each chunk it pulses the engine's `run`, then waits for engine completion.
- Reports overall completion and error status; a non-OKAY write response aborts the job.

---
 rtl/axi_seq_pkg.sv | 27 ++
 rtl/axi_chunk_calc.sv | 29 ++
 rtl/axi_write_seq.sv | 142 ++++++++++++++
 tb/tb_axi_write_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_seq_pkg.sv
// Shared types and constants for the AXI write sequencer and its chunk calculator.
package axi_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } seq_state_e;

    // Largest chunk handed to the engine in one run, in bytes.
    localparam int MAX_CHUNK = 256;

    // Bursts must never straddle this address boundary.
    localparam int BOUNDARY = 4096;

    // Write response value meaning success.
    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // Bytes left before the next boundary; 13 bits because an aligned address yields 4096.
    function automatic logic [12:0] bytes_to_boundary(input logic [11:0] addr_lo);
        return 13'(BOUNDARY) - {1'b0, addr_lo};
    endfunction

endpackage

// File: rtl/axi_chunk_calc.sv
// Combinational chunk sizing: min(remaining, 256, bytes to the next 4 KiB boundary).
module axi_chunk_calc
    import axi_seq_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic [11:0]          cur_addr,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [8:0]           chunk
);

    // Common comparison width so neither operand is silently truncated.
    localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    logic [CW-1:0] to_boundary_w;
    logic [CW-1:0] cap_w;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] min_w;

    // Clamp to the burst cap first, then to whatever is left of the job.
    always_comb begin
        to_boundary_w = CW'(bytes_to_boundary(cur_addr));
        rem_w         = CW'(remaining);
        cap_w         = (to_boundary_w < CW'(MAX_CHUNK)) ? to_boundary_w : CW'(MAX_CHUNK);
        min_w         = (rem_w < cap_w) ? rem_w : cap_w;
        chunk         = 9'(min_w);
    end

endmodule

// File: rtl/axi_write_seq.sv
// Job sequencer: splits one write job into boundary-safe chunks and drives the burst engine.
module axi_write_seq
    import axi_seq_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int LEN_WIDTH          = 16
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] job_addr,
    input  logic [LEN_WIDTH-1:0]          job_len,
    output logic                          eng_run,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] eng_start_addr,
    output logic [8:0]                    eng_byte_length,
    input  logic                          eng_done,
    input  logic [1:0]                    eng_bresp,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [7:0]                    chunk_count
);

    // Address and length must be whole engine beats.
    localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int GRAN_BITS  = $clog2(BEAT_BYTES);

    seq_state_e                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]          remaining_q, remaining_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
    logic [8:0]                    byte_len_q, byte_len_d;
    logic                          err_q, err_d;
    logic [7:0]                    count_q, count_d;
    logic [8:0]                    chunk;
    logic                          job_illegal;

    axi_chunk_calc #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_chunk_calc (
        .cur_addr  (cur_addr_q[11:0]),
        .remaining (remaining_q),
        .chunk     (chunk)
    );

    assign job_illegal = (job_len == '0)
                      || (job_len[GRAN_BITS-1:0] != '0)
                      || (job_addr[GRAN_BITS-1:0] != '0);

    // Next-state logic: job intake, chunk issue and per-chunk bookkeeping.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        start_addr_d = start_addr_q;
        byte_len_d   = byte_len_q;
        err_d        = err_q;
        count_d      = count_q;
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    cur_addr_d  = job_addr;
                    remaining_d = job_len;
                    err_d       = 1'b0;
                    count_d     = 8'd0;
                    if (job_illegal) begin
                        // Rejected jobs still finish with a done pulse so the requester is released.
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                start_addr_d = cur_addr_q;
                byte_len_d   = chunk;
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    // Address wraps silently at the top of the address space.
                    cur_addr_d  = cur_addr_q + C_M_AXI_ADDR_WIDTH'(byte_len_q);
                    remaining_d = remaining_q - LEN_WIDTH'(byte_len_q);
                    if (eng_bresp != BRESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (remaining_d == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any chunk in flight.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            start_addr_q <= '0;
            byte_len_q   <= '0;
            err_q        <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            start_addr_q <= start_addr_d;
            byte_len_q   <= byte_len_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    assign job_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign eng_run         = (state_q == S_RUN);
    assign done            = (state_q == S_FIN);
    assign eng_start_addr  = start_addr_q;
    assign eng_byte_length = byte_len_q;
    assign err             = err_q;
    assign chunk_count     = count_q;

endmodule

// File: tb/tb_axi_write_seq.sv
// Scoreboard bench for axi_write_seq: a job-level model predicts chunks and results,
// an engine responder answers eng_run, and a monitor compares whatever the DUT presents.
module tb_axi_write_seq;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_addr;
    logic [15:0] job_len;
    logic        eng_run;
    logic [31:0] eng_start_addr;
    logic [8:0]  eng_byte_length;
    logic        eng_done;
    logic [1:0]  eng_bresp;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  chunk_count;

    always #5 clk = ~clk;

    axi_write_seq #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (64),
        .LEN_WIDTH          (16)
    ) dut (
        .m_axi_aclk      (clk),
        .m_axi_aresetn   (aresetn),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_addr        (job_addr),
        .job_len         (job_len),
        .eng_run         (eng_run),
        .eng_start_addr  (eng_start_addr),
        .eng_byte_length (eng_byte_length),
        .eng_done        (eng_done),
        .eng_bresp       (eng_bresp),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .chunk_count     (chunk_count)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;   // number of rising edges so far
    int trig       = 0;   // cycle of the last event that launches the next eng_run / done
    bit hold_resp  = 1'b0;

    logic [40:0] exp_chunk_q[$];   // {addr, len}
    logic [1:0]  bresp_q[$];       // response to return for each issued chunk
    logic [8:0]  exp_res_q[$];     // {err, chunk_count}

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Job-level reference: walk the job byte range in boundary-safe pieces.
    task automatic model_job(input logic [31:0] addr, input int len, input int err_idx);
        logic [31:0] a;
        int r, c, n;
        bit e;
        if (len == 0 || (len % 8) != 0 || (addr % 8) != 0) begin
            exp_res_q.push_back({1'b1, 8'd0});
            return;
        end
        a = addr; r = len; n = 0; e = 1'b0;
        while (r > 0) begin
            c = r;
            if (c > 256) c = 256;
            if (c > 4096 - int'(a % 4096)) c = 4096 - int'(a % 4096);
            exp_chunk_q.push_back({a, 9'(c)});
            if (n == err_idx) begin
                bresp_q.push_back(2'($urandom_range(1, 3)));
                e = 1'b1;
            end else begin
                bresp_q.push_back(2'b00);
            end
            n++;
            if (e) break;
            a = a + 32'(c);
            r = r - c;
        end
        exp_res_q.push_back({e, 8'((n > 255) ? 255 : n)});
    endtask

    task automatic issue(input logic [31:0] addr, input int len, input int err_idx);
        int i;
        model_job(addr, len, err_idx);
        @(negedge clk);
        job_valid = 1'b1;
        job_addr  = addr;
        job_len   = 16'(len);
        for (i = 0; i < 100 && !job_ready; i++) @(negedge clk);
        if (!job_ready) check("accept_timeout", 0, 1);
        trig = cyc;
        $display("job addr=%08h len=%0d err_idx=%0d accepted at cycle %0d", addr, len, err_idx, cyc + 1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 20000 && !done; i++) @(negedge clk);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_job(input logic [31:0] addr, input int len, input int err_idx);
        issue(addr, len, err_idx);
        wait_done();
    endtask

    // Engine model: answer each eng_run after a random delay, checking the chunk stays stable.
    initial begin : responder
        logic [31:0] sa;
        logic [8:0]  sl;
        logic [1:0]  br;
        eng_done  = 1'b0;
        eng_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (eng_run && !hold_resp) begin
                sa = eng_start_addr;
                sl = eng_byte_length;
                br = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                check("hold_addr", eng_start_addr, sa);
                check("hold_len", eng_byte_length, sl);
                eng_done  = 1'b1;
                eng_bresp = br;
                trig      = cyc;
                @(negedge clk);
                eng_done  = 1'b0;
                eng_bresp = 2'b00;
            end
        end
    end

    // Monitor: compare every eng_run and done against the scoreboard queues.
    initial begin : monitor
        logic [40:0] ec;
        logic [8:0]  er;
        bit prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) check("ready_after_done", job_ready, 1);
            prev_done = done;
            if (eng_run) begin
                if (exp_chunk_q.size() == 0) begin
                    check("unexpected_eng_run", eng_run, 0);
                end else begin
                    ec = exp_chunk_q.pop_front();
                    $display("chunk addr=%08h len=%0d (expected %08h/%0d) cycle %0d",
                             eng_start_addr, eng_byte_length, ec[40:9], ec[8:0], cyc);
                    check("run_addr", eng_start_addr, ec[40:9]);
                    check("run_len", eng_byte_length, ec[8:0]);
                    check("run_latency", cyc - trig, 2);
                end
            end
            if (done) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    er = exp_res_q.pop_front();
                    $display("done err=%0d chunk_count=%0d (expected %0d/%0d) cycle %0d",
                             err, chunk_count, er[8], er[7:0], cyc);
                    check("err", err, er[8]);
                    check("chunk_count", chunk_count, er[7:0]);
                    check("done_latency", cyc - trig, 1);
                    check("missing_runs", exp_chunk_q.size(), 0);
                    check("busy_at_done", busy, 1);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_job_ready"}, job_ready, 1);
        check({tag, "_eng_run"}, eng_run, 0);
        check({tag, "_eng_start_addr"}, eng_start_addr, 0);
        check({tag, "_eng_byte_length"}, eng_byte_length, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_chunk_count"}, chunk_count, 0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] ra;
        int rl, re, i;
        aresetn   = 1'b0;
        job_valid = 1'b0;
        job_addr  = '0;
        job_len   = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        aresetn = 1'b1;

        // Directed cases
        run_job(32'h0000_1000, 64, -1);
        run_job(32'h0000_0000, 600, -1);
        run_job(32'h0000_0FC0, 256, -1);
        run_job(32'h0000_0000, 600, 0);
        run_job(32'h0000_0000, 0, -1);
        run_job(32'h0000_0000, 12, -1);
        run_job(32'h0000_0004, 64, -1);
        run_job(32'hFFFF_FF80, 512, -1);        // address wrap
        run_job(32'h0000_0F08, 65528, -1);      // 256 chunks, count saturates

        // Reset while waiting for the engine
        hold_resp = 1'b1;
        issue(32'h0000_3000, 1024, -1);
        for (i = 0; i < 20 && !eng_run; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        check_reset_values("midjob_reset");
        aresetn = 1'b1;
        exp_chunk_q.delete();
        bresp_q.delete();
        exp_res_q.delete();
        hold_resp = 1'b0;
        run_job(32'h0000_2000, 8, -1);

        // Randomized jobs
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            ra[2:0] = 3'b000;
            rl = $urandom_range(1, 400) * 8;
            re = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
            case ($urandom_range(0, 9))
                0: ra[2:0] = 3'(($urandom_range(1, 7)));
                1: rl = rl + $urandom_range(1, 7);
                default: ;
            endcase
            if (rl > 65535) rl = 65528;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_job(ra, rl, re);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
